ahb_master_driver: RTL and testbench



---
 rtl/ahb_master_driver.sv | 205 ++++++++++++++++++++
 tb/tb_ahb_master_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_driver.sv
// AHB-Lite initiator: single/INCR burst commands to pipelined address/data phases.
// Optional error-abort behaviour enabled by defining AHB_MST_ERR_ABORT_EN.
module ahb_master_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wd_data,
    output logic        wd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] Haddr,
    output logic [1:0]  Htrans,
    output logic        Hwrite,
    output logic [2:0]  Hsize,
    output logic [2:0]  Hburst,
    output logic [31:0] Hwdata,
    input  logic        Hreadyout,
    input  logic [1:0]  Hresp,
    input  logic [31:0] Hrdata
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
`ifdef AHB_MST_ERR_ABORT_EN
        S_LAST = 2'd2,
        S_ERR  = 2'd3
`else
        S_LAST = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [3:0]  beats_q, beats_d;
    logic        dphase_q, dphase_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        eflag_q, eflag_d;

    logic [31:0] haddr_inc;
    logic        err_resp;

    // An ERROR response only means something while a data phase is outstanding.
    assign err_resp  = dphase_q && (Hresp == RESP_ERR);
    assign haddr_inc = haddr_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TR_IDLE;
            hwrite_q   <= 1'b0;
            hburst_q   <= '0;
            hwdata_q   <= '0;
            beats_q    <= '0;
            dphase_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            eflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            beats_q    <= beats_d;
            dphase_q   <= dphase_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            eflag_q    <= eflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = S_ADDR;
            S_ADDR: if (Hreadyout && beats_q == '0) state_d = S_LAST;
            S_LAST: if (Hreadyout) state_d = S_IDLE;
`ifdef AHB_MST_ERR_ABORT_EN
            S_ERR:  if (Hreadyout) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef AHB_MST_ERR_ABORT_EN
        if (err_resp && (state_q == S_ADDR || state_q == S_LAST)) begin
            state_d = Hreadyout ? S_IDLE : S_ERR;
        end
`endif
    end

    always_comb begin
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        beats_d    = beats_q;
        dphase_d   = dphase_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        eflag_d    = eflag_q | err_resp;
        wd_ready   = 1'b0;

        // Each completed address phase opens exactly one data phase.
        if (Hreadyout) begin
            dphase_d = (state_q == S_ADDR);
        end
        if (Hreadyout && dphase_q && !hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = Hrdata;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    haddr_d  = cmd_addr;
                    htrans_d = TR_NONSEQ;
                    hwrite_d = cmd_write;
                    hburst_d = (cmd_len == '0) ? 3'b000 : 3'b001;
                    beats_d  = cmd_len;
                    eflag_d  = 1'b0;
                end
            end
            S_ADDR: begin
                if (Hreadyout) begin
                    if (hwrite_q) begin
                        hwdata_d = wd_data;
                        wd_ready = 1'b1;
                    end
                    if (beats_q != '0) begin
                        haddr_d  = haddr_inc;
                        beats_d  = beats_q - 4'd1;
                        htrans_d = (haddr_inc[9:0] == '0) ? TR_NONSEQ : TR_SEQ;
                    end else begin
                        htrans_d = TR_IDLE;
                    end
                end
            end
            S_LAST: begin
                if (Hreadyout) begin
                    done_d = 1'b1;
                    err_d  = eflag_q | err_resp;
                end
            end
            default: ;
        endcase

`ifdef AHB_MST_ERR_ABORT_EN
        // Abort overrides the normal progress: cancel remaining beats, drop the errored read.
        if (state_q == S_ERR || err_resp) begin
            htrans_d   = TR_IDLE;
            beats_d    = '0;
            haddr_d    = haddr_q;
            hwdata_d   = hwdata_q;
            wd_ready   = 1'b0;
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data_q;
            if (Hreadyout) begin
                done_d   = 1'b1;
                err_d    = 1'b1;
                dphase_d = 1'b0;
            end
        end
`endif
    end

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign Haddr     = haddr_q;
    assign Htrans    = htrans_q;
    assign Hwrite    = hwrite_q;
    assign Hsize     = 3'b010;
    assign Hburst    = hburst_q;
    assign Hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_driver.sv
// Directed bench for ahb_master_driver: per-cycle vector table plus stall, error and reset sequences.
module tb_ahb_master_driver;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wd_data;
    logic        wd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    ahb_master_driver dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_data(wd_data), .wd_ready(wd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_hw;
        logic [2:0]  e_burst;
        logic [31:0] e_wdata;
        logic        e_wdr;
        logic        e_rdv;
        logic [31:0] e_rdata;
        logic        e_done;
        logic        e_err;
        logic        e_crdy;
    } vec_t;

    localparam int NV = 20;
`ifdef AHB_MST_ERR_ABORT_EN
    localparam int ERR_DONE_C = 6;
    localparam int ERR_RV     = 2;
    localparam int ERR_ISSUED = 3;
`else
    localparam int ERR_DONE_C = 11;
    localparam int ERR_RV     = 8;
    localparam int ERR_ISSUED = 8;
`endif

    vec_t        vecs [NV];
    logic [31:0] wds      [0:3];
    logic [31:0] st_addr  [1:7];
    logic [1:0]  st_trans [1:7];
    logic [31:0] st_wdata [1:7];

    int errors = 0;
    int checks = 0;
    int wd_idx, wr_cnt, dn, rv, issued;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // '{vld,wr,addr,len,wd,rdy,rdata, e_trans,e_addr,e_hw,e_burst,e_wdata,e_wdr,e_rdv,e_rdata,e_done,e_err,e_crdy}
        vecs[0]  = '{1'b1,1'b1,32'h80000000,4'd0,32'hA5A5A5A5,1'b1,32'h0, 2'b00,32'h00000000,1'b0,3'b000,32'h00000000,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1};
        vecs[1]  = '{1'b0,1'b0,32'h0,4'd0,32'hA5A5A5A5,1'b1,32'h0, 2'b10,32'h80000000,1'b1,3'b000,32'h00000000,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,32'h0,4'd0,32'h11111111,1'b1,32'h0, 2'b00,32'h80000000,1'b1,3'b000,32'hA5A5A5A5,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,32'h84000000,4'd3,32'h0,1'b1,32'h0, 2'b00,32'h80000000,1'b1,3'b000,32'hA5A5A5A5,1'b0,1'b0,32'h0,1'b1,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h0, 2'b10,32'h84000000,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h1, 2'b11,32'h84000004,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h2, 2'b11,32'h84000008,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'h1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h3, 2'b11,32'h8400000C,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'h2,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h4, 2'b00,32'h8400000C,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'h3,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h0, 2'b00,32'h8400000C,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'h4,1'b1,1'b0,1'b1};
        vecs[10] = '{1'b1,1'b0,32'h800003F8,4'd2,32'h0,1'b1,32'h0, 2'b00,32'h8400000C,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'h4,1'b0,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h0, 2'b10,32'h800003F8,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'h4,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'hA1, 2'b11,32'h800003FC,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'h4,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'hA2, 2'b10,32'h80000400,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'hA1,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'hA3, 2'b00,32'h80000400,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'hA2,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,32'hFFFFFFFC,4'd1,32'h0,1'b1,32'h0, 2'b00,32'h80000400,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'hA3,1'b1,1'b0,1'b1};
        vecs[16] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h0, 2'b10,32'hFFFFFFFC,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'hA3,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'hB1, 2'b10,32'h00000000,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b0,32'hA3,1'b0,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'hB2, 2'b00,32'h00000000,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'hB1,1'b0,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,32'h0, 2'b00,32'h00000000,1'b0,3'b001,32'hA5A5A5A5,1'b0,1'b1,32'hB2,1'b1,1'b0,1'b1};

        wds      = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
        st_addr  = '{32'h90000000, 32'h90000004, 32'h90000004, 32'h90000004, 32'h90000008, 32'h9000000C, 32'h9000000C};
        st_trans = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        st_wdata = '{32'hA5A5A5A5, 32'hC0DE0000, 32'hC0DE0000, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_data = '0; Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_trans", Htrans, 2'b00);
        chk("rst_addr", Haddr, 32'h0);
        chk("rst_hwrite", Hwrite, 1'b0);
        chk("rst_hburst", Hburst, 3'b000);
        chk("rst_hwdata", Hwdata, 32'h0);
        chk("rst_hsize", Hsize, 3'b010);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_wd_ready", wd_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: single write, 4-beat read, 1 KB boundary and address wrap
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            cmd_valid = vecs[i].vld;  cmd_write = vecs[i].wr;
            cmd_addr  = vecs[i].addr; cmd_len   = vecs[i].len;
            wd_data   = vecs[i].wd;   Hreadyout = vecs[i].rdy;
            Hresp     = 2'b00;        Hrdata    = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_trans", i), Htrans, vecs[i].e_trans);
            chk($sformatf("v%0d_addr", i), Haddr, vecs[i].e_addr);
            chk($sformatf("v%0d_hwrite", i), Hwrite, vecs[i].e_hw);
            chk($sformatf("v%0d_hburst", i), Hburst, vecs[i].e_burst);
            chk($sformatf("v%0d_hwdata", i), Hwdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_wd_ready", i), wd_ready, vecs[i].e_wdr);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_rdv);
            chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rdata);
            chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vecs[i].e_crdy);
        end

        // 4-beat write with two wait states on beat 2
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h90000000; cmd_len = 4'd3;
        Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = '0;
        wd_idx = 0; wr_cnt = 0; dn = 0;
        wd_data = wds[0];
        #1;
        chk("stall_accept", cmd_ready, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            Hreadyout = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            wd_data = (wd_idx < 4) ? wds[wd_idx] : 32'h0;
            #1;
            if (wd_ready) begin
                wr_cnt++;
                wd_idx++;
            end
            if (done) dn++;
            if (c <= 7) begin
                chk($sformatf("stall_c%0d_addr", c), Haddr, st_addr[c]);
                chk($sformatf("stall_c%0d_trans", c), Htrans, st_trans[c]);
                chk($sformatf("stall_c%0d_hwdata", c), Hwdata, st_wdata[c]);
            end
            if (c == 8) chk("stall_done", done, 1'b1);
        end
        chk("stall_wd_ready_pulses", wr_cnt, 4);
        chk("stall_done_count", dn, 1);

        // 8-beat read, ERROR on beat 3
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA0000000; cmd_len = 4'd7;
        Hreadyout = 1'b1; Hresp = 2'b00;
        rv = 0; dn = 0; issued = 0;
        #1;
        chk("err_accept", cmd_ready, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            Hreadyout = (c == 4) ? 1'b0 : 1'b1;
            Hresp = (c == 4 || c == 5) ? 2'b01 : 2'b00;
            Hrdata = 32'h100 + c;
            #1;
            if (Htrans != 2'b00 && Hreadyout) issued++;
            if (rd_valid) rv++;
            if (c == 3) chk("err_first_rd_data", rd_data, 32'h102);
            if (done) begin
                dn++;
                chk("err_done_err", err, 1'b1);
                chk("err_done_cycle", c, ERR_DONE_C);
            end
`ifdef AHB_MST_ERR_ABORT_EN
            if (c == 5) chk("err_abort_trans", Htrans, 2'b00);
`else
            if (c == 5) chk("err_hold_trans", Htrans, 2'b11);
`endif
        end
        chk("err_rd_valid_count", rv, ERR_RV);
        chk("err_beats_issued", issued, ERR_ISSUED);
        chk("err_done_count", dn, 1);

        // Reset in the middle of a 16-beat burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hB0000000; cmd_len = 4'd15;
        Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = 32'h55;
        dn = 0;
        #1;
        chk("rstm_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstm_c3_trans", Htrans, 2'b11);
        chk("rstm_c3_addr", Haddr, 32'hB0000008);
        @(negedge clk);
        #1;
        chk("rstm_trans", Htrans, 2'b00);
        chk("rstm_addr", Haddr, 32'h0);
        chk("rstm_cmd_ready", cmd_ready, 1'b0);
        chk("rstm_rd_valid", rd_valid, 1'b0);
        chk("rstm_rd_data", rd_data, 32'h0);
        chk("rstm_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC0000000; cmd_len = 4'd0;
        wd_data = 32'h5A5A5A5A;
        #1;
        chk("rstm_release_ready", cmd_ready, 1'b1);
        chk("rstm_release_done", done, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("post_trans", Htrans, 2'b10);
        chk("post_addr", Haddr, 32'hC0000000);
        chk("post_wd_ready", wd_ready, 1'b1);
        chk("post_hburst", Hburst, 3'b000);
        @(negedge clk);
        wd_data = 32'h0;
        #1;
        chk("post_hwdata", Hwdata, 32'h5A5A5A5A);
        chk("post_last_trans", Htrans, 2'b00);
        @(negedge clk);
        #1;
        chk("post_done", done, 1'b1);
        chk("post_err", err, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
